branch_hazard_ctrl: RTL and testbench

//  Pipeline control stage directly downstream of the blt/bne hazard detector. It consumes

---
 rtl/branch_hazard_ctrl_pkg.sv | 15 +
 rtl/branch_hazard_ctrl_if.sv | 32 +++
 rtl/branch_hazard_ctrl_sat_down_counter.sv | 22 ++
 rtl/branch_hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_branch_hazard_ctrl.sv | 137 +++++++++++++
 5 files changed

// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared opcode constants and FSM state encoding for the branch hazard control stage.
package branch_hazard_ctrl_pkg;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_LW   = 5'b01000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STALL   = 2'd1,
    RESOLVE = 2'd2,
    FLUSH   = 2'd3
  } state_t;

endpackage

// File: rtl/branch_hazard_ctrl_if.sv
// Detector/pipeline <-> branch hazard control bundle. The stat_* counters exist only
// when BRANCH_STATS_EN is defined.
interface branch_hazard_ctrl_if;
  logic        b_now, pass, prob_rs, prob_rd, ld_old, taken;
  logic        stall_pc, stall_fd, bubble_dx, flush_fd, flush_dx;
  logic        byp_rs, byp_rd, busy;
`ifdef BRANCH_STATS_EN
  logic [15:0] stat_taken, stat_stall;

  modport master (
    output b_now, pass, prob_rs, prob_rd, ld_old, taken,
    input  stall_pc, stall_fd, bubble_dx, flush_fd, flush_dx,
           byp_rs, byp_rd, busy, stat_taken, stat_stall
  );
  modport slave (
    input  b_now, pass, prob_rs, prob_rd, ld_old, taken,
    output stall_pc, stall_fd, bubble_dx, flush_fd, flush_dx,
           byp_rs, byp_rd, busy, stat_taken, stat_stall
  );
`else
  modport master (
    output b_now, pass, prob_rs, prob_rd, ld_old, taken,
    input  stall_pc, stall_fd, bubble_dx, flush_fd, flush_dx,
           byp_rs, byp_rd, busy
  );
  modport slave (
    input  b_now, pass, prob_rs, prob_rd, ld_old, taken,
    output stall_pc, stall_fd, bubble_dx, flush_fd, flush_dx,
           byp_rs, byp_rd, busy
  );
`endif
endinterface

// File: rtl/branch_hazard_ctrl_sat_down_counter.sv
// Loadable down-counter that saturates at zero; shared by the STALL and FLUSH windows.
module sat_down_counter #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                    cnt <= '0;
    else if (load)                cnt <= load_val;
    else if (dec && cnt != '0)    cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Branch hazard control: load-use stall, comparator bypass selects, taken-branch flush.
// Optional BRANCH_STATS_EN adds saturating taken/stall event counters.
module branch_hazard_ctrl
  import branch_hazard_ctrl_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 2,
  parameter int FLUSH_CYCLES      = 2,
  parameter int CNT_W             = 3
) (
  input  logic             clock,
  input  logic             reset,
  branch_hazard_ctrl_if.slave bus
);

  state_t            state, nxt;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_zero, cnt_load, cnt_dec;
  logic [CNT_W-1:0]  cnt_val;
  logic              ld_hz, accept;
  logic              stall_c, flush_fd_c, flush_dx_c;
  logic              byp_rs_n, byp_rd_n, byp_rs_q, byp_rd_q;
  logic              taken_ev, stall_ev;

  assign ld_hz = bus.b_now & bus.ld_old & (bus.prob_rs | bus.prob_rd);

  sat_down_counter #(.W(CNT_W)) u_cnt (
    .clock(clock), .reset(reset), .load(cnt_load), .load_val(cnt_val),
    .dec(cnt_dec), .cnt(cnt), .zero(cnt_zero)
  );

  always_comb begin
    nxt        = state;
    accept     = 1'b0;
    stall_c    = 1'b0;
    flush_fd_c = 1'b0;
    flush_dx_c = 1'b0;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    cnt_dec    = 1'b0;
    byp_rs_n   = 1'b0;
    byp_rd_n   = 1'b0;
    taken_ev   = 1'b0;
    stall_ev   = 1'b0;
    case (state)
      IDLE:    accept = 1'b1;
      RESOLVE: begin
        if (bus.taken) begin
          flush_fd_c = 1'b1;
          flush_dx_c = 1'b1;
          cnt_load   = 1'b1;
          cnt_val    = CNT_W'(FLUSH_CYCLES - 1);
          taken_ev   = 1'b1;
          nxt        = (FLUSH_CYCLES == 1) ? IDLE : FLUSH;
        end else begin
          accept = 1'b1;
        end
      end
      // The count reaches zero on this edge when cnt<=1, so the window ends here.
      STALL: begin
        stall_c = 1'b1;
        cnt_dec = 1'b1;
        if (cnt_zero || cnt == CNT_W'(1)) nxt = IDLE;
      end
      FLUSH: begin
        flush_fd_c = 1'b1;
        cnt_dec    = 1'b1;
        if (cnt_zero || cnt == CNT_W'(1)) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
    // Load-use beats bypass: stall first, the held branch is re-decided afterwards.
    if (accept) begin
      if (ld_hz) begin
        stall_c  = 1'b1;
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(LOAD_STALL_CYCLES - 1);
        stall_ev = 1'b1;
        nxt      = (LOAD_STALL_CYCLES == 1) ? IDLE : STALL;
      end else if (bus.b_now) begin
        byp_rs_n = bus.pass & bus.prob_rs;
        byp_rd_n = bus.pass & bus.prob_rd;
        nxt      = RESOLVE;
      end else begin
        nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      byp_rs_q <= 1'b0;
      byp_rd_q <= 1'b0;
    end else begin
      state    <= nxt;
      byp_rs_q <= byp_rs_n;
      byp_rd_q <= byp_rd_n;
    end
  end

  // Mealy outputs are masked while reset is held so nothing leaks from live inputs.
  assign bus.stall_pc  = stall_c & ~reset;
  assign bus.stall_fd  = stall_c & ~reset;
  assign bus.bubble_dx = stall_c & ~reset;
  assign bus.flush_fd  = flush_fd_c & ~reset;
  assign bus.flush_dx  = flush_dx_c & ~reset;
  assign bus.byp_rs    = byp_rs_q;
  assign bus.byp_rd    = byp_rd_q;
  assign bus.busy      = (state != IDLE);

`ifdef BRANCH_STATS_EN
  logic [15:0] st_taken_q, st_stall_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_taken_q <= '0;
      st_stall_q <= '0;
    end else begin
      if (taken_ev && st_taken_q != 16'hFFFF) st_taken_q <= st_taken_q + 16'd1;
      if (stall_ev && st_stall_q != 16'hFFFF) st_stall_q <= st_stall_q + 16'd1;
    end
  end

  assign bus.stat_taken = st_taken_q;
  assign bus.stat_stall = st_stall_q;
`else
  logic unused_ev;
  assign unused_ev = taken_ev ^ stall_ev;
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl; output vector order is
// {stall_pc, stall_fd, bubble_dx, flush_fd, flush_dx, byp_rs, byp_rd, busy}.
module tb_branch_hazard_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  branch_hazard_ctrl_if bus ();

  branch_hazard_ctrl #(
    .LOAD_STALL_CYCLES(2), .FLUSH_CYCLES(2), .CNT_W(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  logic [7:0] outs;
  assign outs = {bus.stall_pc, bus.stall_fd, bus.bubble_dx, bus.flush_fd,
                 bus.flush_dx, bus.byp_rs, bus.byp_rd, bus.busy};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic b, input logic p, input logic rs, input logic rd,
                     input logic ld, input logic tk);
    bus.b_now   = b;
    bus.pass    = p;
    bus.prob_rs = rs;
    bus.prob_rd = rd;
    bus.ld_old  = ld;
    bus.taken   = tk;
  endtask

  // Check the current cycle mid-period, then advance past the next rising edge.
  task automatic step(input string tag, input logic [7:0] exp);
    @(negedge clock);
    chk(tag, {24'h0, outs}, {24'h0, exp});
    @(posedge clock);
    #1;
  endtask

  initial begin
    // 1: reset dominates live branch/taken inputs
    drv(1, 1, 1, 0, 0, 1);
    step("rst_a", 8'b0000_0000);
    step("rst_b", 8'b0000_0000);
    reset = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    step("idle", 8'b0000_0000);

    // 2: forwarded rs operand, not taken
    drv(1, 1, 1, 0, 0, 0);
    step("byp_acc", 8'b0000_0000);
    drv(0, 0, 0, 0, 0, 0);
    step("byp_res", 8'b0000_0101);
    step("byp_idl", 8'b0000_0000);

    // 3: load-use on rd, two stall cycles, then the held branch resolves
    drv(1, 1, 0, 1, 1, 0);
    step("ld_st0", 8'b1110_0000);
    step("ld_st1", 8'b1110_0001);
    drv(1, 1, 0, 1, 0, 0);
    step("ld_reev", 8'b0000_0000);

    // 4: taken in RESOLVE, branch during FLUSH ignored
    drv(0, 0, 0, 0, 0, 1);
    step("tk_res", 8'b0001_1011);
    drv(1, 1, 1, 0, 0, 0);
    step("tk_fl", 8'b0001_0001);
    drv(0, 0, 0, 0, 0, 0);
    step("tk_idl", 8'b0000_0000);

    // 5: taken and new branch together -> new branch dropped
    drv(1, 1, 1, 1, 0, 0);
    step("tb_acc", 8'b0000_0000);
    drv(1, 1, 1, 1, 0, 1);
    step("tb_res", 8'b0001_1111);
    drv(0, 0, 0, 0, 0, 0);
    step("tb_fl", 8'b0001_0001);
    step("tb_idl", 8'b0000_0000);

    // 7: not-taken RESOLVE followed by a load-use branch back to back
    drv(1, 1, 1, 0, 0, 0);
    step("bb_acc", 8'b0000_0000);
    drv(1, 1, 1, 0, 1, 0);
    step("bb_res", 8'b1110_0101);
    step("bb_st", 8'b1110_0001);
    drv(0, 0, 0, 0, 0, 0);
    step("bb_idl", 8'b0000_0000);

`ifdef BRANCH_STATS_EN
    chk("st_tk", {16'h0, bus.stat_taken}, 32'd2);
    chk("st_sl", {16'h0, bus.stat_stall}, 32'd2);
`endif

    // 6: reset asserted in the first STALL cycle
    drv(1, 0, 1, 0, 1, 0);
    step("rs_st0", 8'b1110_0000);
    @(negedge clock);
    chk("rs_st1", {24'h0, outs}, {24'h0, 8'b1110_0001});
`ifdef BRANCH_STATS_EN
    chk("st_sl3", {16'h0, bus.stat_stall}, 32'd3);
`endif
    #1 reset = 1'b1;
    #1;
    chk("rs_drop", {24'h0, outs}, 32'h0);
`ifdef BRANCH_STATS_EN
    chk("st_clr", {16'h0, bus.stat_stall}, 32'd0);
    chk("st_tclr", {16'h0, bus.stat_taken}, 32'd0);
`endif
    @(posedge clock);
    #1;
    reset = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    step("rs_idl", 8'b0000_0000);
    // counter cleared: a fresh load-use still gives exactly two stall cycles
    drv(1, 0, 0, 1, 1, 0);
    step("rs_ld0", 8'b1110_0000);
    step("rs_ld1", 8'b1110_0001);
    drv(0, 0, 0, 0, 0, 0);
    step("rs_ld2", 8'b0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
